mc_controller: RTL and testbench
================================

// Module: mc_controller
// PURPOSE
//  Multicycle control FSM for the 32-bit datapath. Consumes the instruction-class, opcode, immediate,
//  load/store, link and condition fields that the datapath decodes from IR.
//  Drives every mux select, register enable and memory strobe of that datapath, one state per cycle.
//  Sits directly upstream of the datapath. Also feeds MemRead/MemWrite to the unified memory.
// PARAMETERS
//  none (all encodings fixed in ctrl_pkg)
// PORTS
//  clk        in   1  clock, all state changes on rising edge
//  rst        in   1  synchronous, active-high reset
//  inst       in   3  IR[29:27] class: 000 data-proc, 010 memory, 101 branch, 111 halt, others = NOP
//  opcode     in   3  IR[22:20] DP op: MOV MVN ADD SUB AND ORR CMP TST = 000..111
//  I          in   1  IR[23] DP operand2: 1 = sext11 immediate, 0 = register Rm
//  LT         in   1  IR[20] memory: 1 = LDR, 0 = STR
//  LB         in   1  IR[26] branch: 1 = link (R15 <= return address)
//  Cond       in   1  condition checker result for IR[31:30] vs stored ZNCV
//  PCWrite, IorD, IRWrite, RmorRd, RegDst, MemtoReg, PCSrc, reg_write, LoadALU, loadZN, loadCV
//             out  1  datapath enables/selects (select 0 = first mux input)
//  AluSrcA    out  2  00 PC, 01 A, 10 zero
//  AluSrcB    out  2  00 B, 01 const 1, 10 sext11, 11 sext25
//  alu_ctrl   out  3  ALU_ADD 000, ALU_SUB 001, ALU_AND 010, ALU_ORR 011, ALU_MOV 100, ALU_MVN 101
//  MemRead    out  1  memory read strobe
//  MemWrite   out  1  memory write strobe
//  halted     out  1  high while in HALT
// BEHAVIOUR
//  - Outputs: combinational from state register plus IR-derived inputs, which are stable after FETCH.
//    While rst=1 every output is 0. Reset loads FETCH at the next edge.
//    An unlisted output is 0 in that state.
//  - FETCH: IorD=0, MemRead, IRWrite, AluSrcA=00, AluSrcB=01, ADD, PCSrc=0, PCWrite, LoadALU.
//    Result: PC<=PC+1, ALUOut<=PC+1 (return address). -> DECODE.
//  - DECODE: RmorRd=(inst==DP). AluSrcA=00, AluSrcB=11, ADD, LoadALU (ALUOut<=branch target).
//    Branch taken (inst==BR & Cond): PCSrc=0, PCWrite=1. If LB also: reg_write, RegDst=1, MemtoReg=1,
//    which writes R15 <= old ALUOut.
//    Next state:
//      Cond=0        -> FETCH, no writes (also for halt)
//      BR            -> FETCH
//      DP            -> DP_EXEC
//      MEM           -> MEM_ADDR
//      halt          -> HALT
//      other classes -> FETCH
//  - DP_EXEC: RmorRd=1, AluSrcA=01, AluSrcB=I?10:00, LoadALU, loadZN=1.
//    ALU op mapping: MOV->MOV, MVN->MVN, ADD->ADD, SUB->SUB, AND->AND, ORR->ORR, CMP->SUB, TST->AND.
//    loadCV=1 only for ADD, SUB, CMP. -> DP_WB.
//  - DP_WB: MemtoReg=1, RegDst=0, reg_write unless opcode is CMP or TST. -> FETCH.
//  - MEM_ADDR: RmorRd=0 (B<=Rd store data), AluSrcA=01, AluSrcB=10, ADD, LoadALU.
//    Next: LT ? MEM_RD : MEM_WR.
//  - MEM_RD: IorD=1, MemRead (MDR captures data at the edge). -> MEM_WB.
//  - MEM_WB: MemtoReg=0, RegDst=0, reg_write. -> FETCH.
//  - MEM_WR: IorD=1, MemWrite, RmorRd=0. -> FETCH.
//  - HALT: halted=1, all enables 0, stays until rst.
//  - Cycle counts: branch/NOP/untaken 2, DP 4, STR 4, LDR 5.
//  - rst asserted in any state: outputs 0 that cycle, FETCH next cycle. No partial write completes.
//  - Illegal state encoding -> FETCH.
// STRUCTURE
//  - ctrl_pkg: state enum (FETCH..HALT, 4-bit), inst class codes, DP opcode codes, ALU_* codes,
//    AluSrcA/AluSrcB select constants.
//  - Sub-module dp_alu_decode: combinational opcode -> {alu_ctrl, loadCV, writes_rd}.
// TESTING
//  - rst=1 for 2 cycles, from any state -> all outputs 0; first cycle after release shows FETCH
//    (IRWrite=PCWrite=MemRead=1).
//  - DP ADD, I=0, Cond=1 -> FETCH, DECODE, DP_EXEC (alu_ctrl=000, AluSrcB=00, loadZN=loadCV=1),
//    DP_WB (reg_write=1, MemtoReg=1), then FETCH.
//  - DP CMP, I=1 -> DP_EXEC alu_ctrl=001, AluSrcB=10; DP_WB reg_write=0.
//    DP AND -> DP_EXEC loadCV=0.
//  - LT=1 memory -> 5 cycles; MEM_RD IorD=1, MemRead=1; MEM_WB reg_write=1, MemtoReg=0.
//    LT=0 -> MEM_WR MemWrite=1, 4 cycles.
//  - Branch, LB=1, Cond=1 -> DECODE PCWrite=1, PCSrc=0, AluSrcB=11, reg_write=1, RegDst=1.
//    Cond=0 -> DECODE all write enables 0, back to FETCH.
//  - inst=111, Cond=1 -> HALT, halted=1 held 10 cycles; rst returns the FSM to FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Encodings shared by the multicycle controller: states, IR field codes, ALU ops, mux selects,
// and the packed bundle of control outputs.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        DP_EXEC  = 4'd2,
        DP_WB    = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WB   = 4'd6,
        MEM_WR   = 4'd7,
        HALT     = 4'd8
    } state_e;

    localparam logic [2:0] INST_DP   = 3'b000;
    localparam logic [2:0] INST_MEM  = 3'b010;
    localparam logic [2:0] INST_BR   = 3'b101;
    localparam logic [2:0] INST_HALT = 3'b111;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_MVN = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_ORR = 3'b101;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_TST = 3'b111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;
    localparam logic [2:0] ALU_MVN = 3'b101;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_A    = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_ONE    = 2'b01;
    localparam logic [1:0] SRCB_SEXT11 = 2'b10;
    localparam logic [1:0] SRCB_SEXT25 = 2'b11;

    typedef struct packed {
        logic       PCWrite;
        logic       IorD;
        logic       IRWrite;
        logic       RmorRd;
        logic       RegDst;
        logic       MemtoReg;
        logic       PCSrc;
        logic       reg_write;
        logic       LoadALU;
        logic       loadZN;
        logic       loadCV;
        logic [1:0] AluSrcA;
        logic [1:0] AluSrcB;
        logic [2:0] alu_ctrl;
        logic       MemRead;
        logic       MemWrite;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: IR-decoded fields in, selects/enables/strobes out.
interface mc_controller_if;
    logic [2:0] inst;
    logic [2:0] opcode;
    logic       I;
    logic       LT;
    logic       LB;
    logic       Cond;

    logic       PCWrite, IorD, IRWrite, RmorRd, RegDst, MemtoReg, PCSrc;
    logic       reg_write, LoadALU, loadZN, loadCV;
    logic [1:0] AluSrcA;
    logic [1:0] AluSrcB;
    logic [2:0] alu_ctrl;
    logic       MemRead, MemWrite, halted;

    modport master (
        input  inst, opcode, I, LT, LB, Cond,
        output PCWrite, IorD, IRWrite, RmorRd, RegDst, MemtoReg, PCSrc,
               reg_write, LoadALU, loadZN, loadCV, AluSrcA, AluSrcB, alu_ctrl,
               MemRead, MemWrite, halted
    );

    modport slave (
        output inst, opcode, I, LT, LB, Cond,
        input  PCWrite, IorD, IRWrite, RmorRd, RegDst, MemtoReg, PCSrc,
               reg_write, LoadALU, loadZN, loadCV, AluSrcA, AluSrcB, alu_ctrl,
               MemRead, MemWrite, halted
    );
endinterface

// File: rtl/mc_controller_dp_alu_decode.sv
// Data-processing opcode decode: ALU operation, carry/overflow flag update, destination write.
module dp_alu_decode
    import ctrl_pkg::*;
(
    input  logic [2:0] opcode_i,
    output logic [2:0] alu_ctrl_o,
    output logic       load_cv_o,
    output logic       writes_rd_o
);
    always_comb begin
        alu_ctrl_o  = ALU_ADD;
        load_cv_o   = 1'b0;
        writes_rd_o = 1'b1;
        case (opcode_i)
            OP_MOV: alu_ctrl_o = ALU_MOV;
            OP_MVN: alu_ctrl_o = ALU_MVN;
            OP_ADD: begin alu_ctrl_o = ALU_ADD; load_cv_o = 1'b1; end
            OP_SUB: begin alu_ctrl_o = ALU_SUB; load_cv_o = 1'b1; end
            OP_AND: alu_ctrl_o = ALU_AND;
            OP_ORR: alu_ctrl_o = ALU_ORR;
            // Compare/test only update flags
            OP_CMP: begin alu_ctrl_o = ALU_SUB; load_cv_o = 1'b1; writes_rd_o = 1'b0; end
            OP_TST: begin alu_ctrl_o = ALU_AND; writes_rd_o = 1'b0; end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle control FSM: one state per datapath cycle, Moore outputs qualified by stable IR fields.
module mc_controller
    import ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mc_controller_if.master  bus
);
    state_e     state_q, state_d;
    ctrl_t      ctrl;
    logic [2:0] dp_alu;
    logic       dp_cv, dp_wr;

    dp_alu_decode u_dp_dec (
        .opcode_i   (bus.opcode),
        .alu_ctrl_o (dp_alu),
        .load_cv_o  (dp_cv),
        .writes_rd_o(dp_wr)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        ctrl    = '0;
        state_d = FETCH;
        case (state_q)
            FETCH: begin
                ctrl.MemRead  = 1'b1;
                ctrl.IRWrite  = 1'b1;
                ctrl.AluSrcA  = SRCA_PC;
                ctrl.AluSrcB  = SRCB_ONE;
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.PCWrite  = 1'b1;
                ctrl.LoadALU  = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                // ALUOut still holds the return address here; branch target replaces it at the edge
                ctrl.RmorRd   = (bus.inst == INST_DP);
                ctrl.AluSrcA  = SRCA_PC;
                ctrl.AluSrcB  = SRCB_SEXT25;
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.LoadALU  = bus.Cond;
                if (bus.Cond) begin
                    case (bus.inst)
                        INST_BR: begin
                            ctrl.PCWrite = 1'b1;
                            if (bus.LB) begin
                                ctrl.reg_write = 1'b1;
                                ctrl.RegDst    = 1'b1;
                                ctrl.MemtoReg  = 1'b1;
                            end
                        end
                        INST_DP:   state_d = DP_EXEC;
                        INST_MEM:  state_d = MEM_ADDR;
                        INST_HALT: state_d = HALT;
                        default:   state_d = FETCH;
                    endcase
                end
            end
            DP_EXEC: begin
                ctrl.RmorRd   = 1'b1;
                ctrl.AluSrcA  = SRCA_A;
                ctrl.AluSrcB  = bus.I ? SRCB_SEXT11 : SRCB_B;
                ctrl.alu_ctrl = dp_alu;
                ctrl.LoadALU  = 1'b1;
                ctrl.loadZN   = 1'b1;
                ctrl.loadCV   = dp_cv;
                state_d       = DP_WB;
            end
            DP_WB: begin
                ctrl.MemtoReg  = 1'b1;
                ctrl.reg_write = dp_wr;
            end
            MEM_ADDR: begin
                ctrl.AluSrcA  = SRCA_A;
                ctrl.AluSrcB  = SRCB_SEXT11;
                ctrl.alu_ctrl = ALU_ADD;
                ctrl.LoadALU  = 1'b1;
                state_d       = bus.LT ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctrl.IorD    = 1'b1;
                ctrl.MemRead = 1'b1;
                state_d      = MEM_WB;
            end
            MEM_WB:  ctrl.reg_write = 1'b1;
            MEM_WR: begin
                ctrl.IorD     = 1'b1;
                ctrl.MemWrite = 1'b1;
            end
            HALT: begin
                ctrl.halted = 1'b1;
                state_d     = HALT;
            end
            default: state_d = FETCH;
        endcase
        // Reset blanks every strobe so no partially issued write can land
        if (rst) ctrl = '0;
    end

    assign bus.PCWrite   = ctrl.PCWrite;
    assign bus.IorD      = ctrl.IorD;
    assign bus.IRWrite   = ctrl.IRWrite;
    assign bus.RmorRd    = ctrl.RmorRd;
    assign bus.RegDst    = ctrl.RegDst;
    assign bus.MemtoReg  = ctrl.MemtoReg;
    assign bus.PCSrc     = ctrl.PCSrc;
    assign bus.reg_write = ctrl.reg_write;
    assign bus.LoadALU   = ctrl.LoadALU;
    assign bus.loadZN    = ctrl.loadZN;
    assign bus.loadCV    = ctrl.loadCV;
    assign bus.AluSrcA   = ctrl.AluSrcA;
    assign bus.AluSrcB   = ctrl.AluSrcB;
    assign bus.alu_ctrl  = ctrl.alu_ctrl;
    assign bus.MemRead   = ctrl.MemRead;
    assign bus.MemWrite  = ctrl.MemWrite;
    assign bus.halted    = ctrl.halted;
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: each stimulus cycle queues the hand-derived control word,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_mc_controller;
    logic clk;
    logic rst;

    mc_controller_if bus ();

    mc_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,IorD,IRWrite,RmorRd,RegDst,MemtoReg,PCSrc,reg_write,LoadALU,loadZN,loadCV},
    // AluSrcA, AluSrcB, alu_ctrl, {MemRead,MemWrite,halted}
    localparam logic [20:0] E_ZERO      = 21'd0;
    localparam logic [20:0] E_FETCH     = {11'b10100000100, 2'b00, 2'b01, 3'b000, 3'b100};
    localparam logic [20:0] E_DEC_DP    = {11'b00010000100, 2'b00, 2'b11, 3'b000, 3'b000};
    localparam logic [20:0] E_DEC_DP_NC = {11'b00010000000, 2'b00, 2'b11, 3'b000, 3'b000};
    localparam logic [20:0] E_DEC_OTH   = {11'b00000000100, 2'b00, 2'b11, 3'b000, 3'b000};
    localparam logic [20:0] E_DEC_NC    = {11'b00000000000, 2'b00, 2'b11, 3'b000, 3'b000};
    localparam logic [20:0] E_DEC_BRL   = {11'b10001101100, 2'b00, 2'b11, 3'b000, 3'b000};
    localparam logic [20:0] E_DEC_BR    = {11'b10000000100, 2'b00, 2'b11, 3'b000, 3'b000};
    localparam logic [20:0] E_EX_ADD    = {11'b00010000111, 2'b01, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_EX_CMP_I  = {11'b00010000111, 2'b01, 2'b10, 3'b001, 3'b000};
    localparam logic [20:0] E_EX_AND    = {11'b00010000110, 2'b01, 2'b00, 3'b010, 3'b000};
    localparam logic [20:0] E_EX_MVN_I  = {11'b00010000110, 2'b01, 2'b10, 3'b101, 3'b000};
    localparam logic [20:0] E_EX_SUB    = {11'b00010000111, 2'b01, 2'b00, 3'b001, 3'b000};
    localparam logic [20:0] E_WB_W      = {11'b00000101000, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_WB_NW     = {11'b00000100000, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_MADDR     = {11'b00000000100, 2'b01, 2'b10, 3'b000, 3'b000};
    localparam logic [20:0] E_MRD       = {11'b01000000000, 2'b00, 2'b00, 3'b000, 3'b100};
    localparam logic [20:0] E_MWB       = {11'b00000001000, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [20:0] E_MWR       = {11'b01000000000, 2'b00, 2'b00, 3'b000, 3'b010};
    localparam logic [20:0] E_HALT      = {11'b00000000000, 2'b00, 2'b00, 3'b000, 3'b001};

    logic [20:0] exp_q[$];
    string       nm_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [20:0] obs;
    assign obs = {bus.PCWrite, bus.IorD, bus.IRWrite, bus.RmorRd, bus.RegDst, bus.MemtoReg,
                  bus.PCSrc, bus.reg_write, bus.LoadALU, bus.loadZN, bus.loadCV,
                  bus.AluSrcA, bus.AluSrcB, bus.alu_ctrl, bus.MemRead, bus.MemWrite, bus.halted};

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [20:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            n_tests++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b", nm, obs, e);
            end
        end
    end

    task automatic ir(input logic [2:0] in, input logic [2:0] op,
                      input logic i_, input logic lt, input logic lb, input logic c);
        bus.inst = in; bus.opcode = op; bus.I = i_; bus.LT = lt; bus.LB = lb; bus.Cond = c;
    endtask

    task automatic step(input logic r, input logic [20:0] e, input string nm);
        rst = r;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ir(3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        step(1'b1, E_ZERO,  "reset_c0");
        step(1'b1, E_ZERO,  "reset_c1");

        // ADD register
        ir(3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "add_fetch");
        step(1'b0, E_DEC_DP,   "add_decode");
        step(1'b0, E_EX_ADD,   "add_exec");
        step(1'b0, E_WB_W,     "add_wb");
        // CMP immediate
        ir(3'b000, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "cmp_fetch");
        step(1'b0, E_DEC_DP,   "cmp_decode");
        step(1'b0, E_EX_CMP_I, "cmp_exec");
        step(1'b0, E_WB_NW,    "cmp_wb");
        // AND, TST, MVN immediate, SUB
        ir(3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "and_fetch");
        step(1'b0, E_DEC_DP,   "and_decode");
        step(1'b0, E_EX_AND,   "and_exec");
        step(1'b0, E_WB_W,     "and_wb");
        ir(3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "tst_fetch");
        step(1'b0, E_DEC_DP,   "tst_decode");
        step(1'b0, E_EX_AND,   "tst_exec");
        step(1'b0, E_WB_NW,    "tst_wb");
        ir(3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "mvn_fetch");
        step(1'b0, E_DEC_DP,   "mvn_decode");
        step(1'b0, E_EX_MVN_I, "mvn_exec");
        step(1'b0, E_WB_W,     "mvn_wb");
        ir(3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "sub_fetch");
        step(1'b0, E_DEC_DP,   "sub_decode");
        step(1'b0, E_EX_SUB,   "sub_exec");
        step(1'b0, E_WB_W,     "sub_wb");
        // LDR: 5 cycles
        ir(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "ldr_fetch");
        step(1'b0, E_DEC_OTH,  "ldr_decode");
        step(1'b0, E_MADDR,    "ldr_addr");
        step(1'b0, E_MRD,      "ldr_rd");
        step(1'b0, E_MWB,      "ldr_wb");
        // STR: 4 cycles
        ir(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "str_fetch");
        step(1'b0, E_DEC_OTH,  "str_decode");
        step(1'b0, E_MADDR,    "str_addr");
        step(1'b0, E_MWR,      "str_wr");
        // Branches
        ir(3'b101, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, E_FETCH,    "bl_fetch");
        step(1'b0, E_DEC_BRL,  "bl_decode");
        ir(3'b101, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "b_fetch");
        step(1'b0, E_DEC_BR,   "b_decode");
        ir(3'b101, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, E_FETCH,    "bl_nc_fetch");
        step(1'b0, E_DEC_NC,   "bl_nc_decode");
        // Untaken DP, NOP class, untaken halt
        ir(3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, E_FETCH,     "dp_nc_fetch");
        step(1'b0, E_DEC_DP_NC, "dp_nc_decode");
        ir(3'b011, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,     "nop_fetch");
        step(1'b0, E_DEC_OTH,   "nop_decode");
        ir(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, E_FETCH,     "hlt_nc_fetch");
        step(1'b0, E_DEC_NC,    "hlt_nc_decode");
        // Reset mid-instruction, before write-back
        ir(3'b000, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "rmid_fetch");
        step(1'b0, E_DEC_DP,   "rmid_decode");
        step(1'b0, E_EX_ADD,   "rmid_exec");
        step(1'b1, E_ZERO,     "rmid_reset");
        step(1'b0, E_FETCH,    "rmid_refetch");
        step(1'b0, E_DEC_DP,   "rmid_decode2");
        step(1'b0, E_EX_ADD,   "rmid_exec2");
        step(1'b0, E_WB_W,     "rmid_wb2");
        // Halt, held 10 cycles, then reset
        ir(3'b111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "hlt_fetch");
        step(1'b0, E_DEC_OTH,  "hlt_decode");
        for (int k = 0; k < 10; k++) step(1'b0, E_HALT, $sformatf("halt_%0d", k));
        step(1'b1, E_ZERO,     "hlt_reset0");
        step(1'b1, E_ZERO,     "hlt_reset1");
        ir(3'b000, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, E_FETCH,    "post_fetch");
        step(1'b0, E_DEC_DP,   "post_decode");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
